// File: rtl/io_tx_port.sv
// io_tx_port: CPU bus write port feeding a 4-deep FIFO and an 8N1 serial sender.
// Ports: clk, rst (async, active-low), bus (inout data/status), seln/from_devn/to_devn
// (active-low select and strobes), tx (serial out, idle high), irqn (low when drained).
module io_tx_port #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus,
  input  logic       seln,
  input  logic       from_devn,
  input  logic       to_devn,
  output logic       tx,
  output logic       irqn
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       ovf;

  state_t     state;
  state_t     state_nx;
  logic [7:0] div_q;
  logic [7:0] div_nx;
  logic [2:0] bit_q;
  logic [2:0] bit_nx;
  logic [7:0] shift_q;

  logic       push;
  logic       rd;
  logic       full;
  logic       empty;
  logic       pop;
  logic       wr_en;
  logic       ovf_set;
  logic       tick;
  logic       busy;
  logic [7:0] status;

  // A write strobe takes precedence: both strobes low is a write.
  assign push    = !seln && !to_devn;
  assign rd      = !seln && !from_devn && to_devn;
  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  // A pop in the same edge frees a slot, so a push into a full FIFO is legal then.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign tick    = (div_q == DIV_LAST);
  assign busy    = (state != IDLE);
  assign status  = {ovf, busy, full, empty, 1'b0, count};
  assign bus     = (rd && rst) ? status : 8'hzz;
  assign irqn    = !(empty && !busy);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (rd) begin
        ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    div_nx   = tick ? 8'd0 : div_q + 8'd1;
    bit_nx   = bit_q;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        div_nx = '0;
        bit_nx = '0;
        if (!empty) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        if (tick) begin
          state_nx = DATA;
          bit_nx   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          bit_nx = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // tx follows the registered state one cycle later, so it never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state <= state_nx;
      div_q <= div_nx;
      bit_q <= bit_nx;
      if (pop) begin
        shift_q <= mem[rd_ptr];
      end else if (state == DATA && tick) begin
        shift_q <= {1'b0, shift_q[7:1]};
      end
      tx <= (state == START) ? 1'b0 :
            (state == DATA)  ? shift_q[0] : 1'b1;
    end
  end

endmodule

// File: tb/tb_io_tx_port.sv
// tb_io_tx_port: scoreboard bench for io_tx_port with CLK_DIV=4.
// A UART receiver and a status-read monitor pop expected values from queues.
module tb_io_tx_port;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seln = 1'b1;
  logic       from_devn = 1'b1;
  logic       to_devn = 1'b1;
  logic       drv = 1'b0;
  logic [7:0] dout = 8'h00;
  wire  [7:0] bus;
  logic       tx;
  logic       irqn;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n0 = 0;
  int lows = 0;

  typedef struct {
    logic [7:0] b;
    bit         b2b;
  } frm_t;

  frm_t       exp_q[$];
  logic [7:0] stat_q[$];
  frm_t       rx_e;
  logic [7:0] st_e;
  int         rx_idx = -1;
  int         rx_t0 = 0;
  int         prev_t0 = 0;
  logic [7:0] rx_byte = 8'h00;

  assign bus = drv ? dout : 8'hzz;

  io_tx_port #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .seln      (seln),
    .from_devn (from_devn),
    .to_devn   (to_devn),
    .tx        (tx),
    .irqn      (irqn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input bit b2b);
    frm_t f;
    f.b = b;
    f.b2b = b2b;
    exp_q.push_back(f);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    drv = 1'b0;
    dout = 8'h00;
    seln = 1'b1;
    to_devn = 1'b1;
    from_devn = 1'b1;
  endtask

  task automatic wr(input logic [7:0] b, input bit both);
    @(negedge clk);
    drv = 1'b1;
    dout = b;
    seln = 1'b0;
    to_devn = 1'b0;
    from_devn = both ? 1'b0 : 1'b1;
    #1 chk("wr_bus", {8'h00, bus}, {8'h00, b});
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] e);
    stat_q.push_back(e);
    @(negedge clk);
    drv = 1'b0;
    seln = 1'b0;
    to_devn = 1'b1;
    from_devn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int i = 0;
    while (i < max && irqn !== 1'b0) begin
      @(negedge clk);
      i++;
    end
    chk("idle_wait", {15'h0, irqn}, 16'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Status monitor: compares the bus once per read strobe.
  always @(negedge from_devn) begin
    #1;
    if (rst && !seln && to_devn && !from_devn) begin
      if (stat_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL status_unexpected: got %h, want none", bus);
      end else begin
        st_e = stat_q.pop_front();
        chk("status", {8'h00, bus}, {8'h00, st_e});
      end
    end
  end

  // Serial receiver: frame cycle index 0 is the first low cycle.
  always @(negedge clk) begin
    if (!rst) begin
      rx_idx = -1;
    end else if (rx_idx < 0) begin
      if (tx == 1'b0) begin
        rx_idx = 0;
        rx_t0 = cyc;
      end
    end else begin
      rx_idx++;
      if (rx_idx == 2) begin
        chk("rx_start", {15'h0, tx}, 16'h0);
      end else if (rx_idx >= 6 && rx_idx <= 34 && (rx_idx - 6) % 4 == 0) begin
        rx_byte[(rx_idx - 6) / 4] = tx;
      end else if (rx_idx == 38) begin
        chk("rx_stop", {15'h0, tx}, 16'h1);
      end else if (rx_idx == 39) begin
        chk("rx_stop_end", {15'h0, tx}, 16'h1);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx_unexpected: got %h, want none", rx_byte);
        end else begin
          rx_e = exp_q.pop_front();
          chk("rx_byte", {8'h00, rx_byte}, {8'h00, rx_e.b});
          if (rx_e.b2b) begin
            chk("rx_gap", 16'(rx_t0 - prev_t0), 16'd40);
          end
        end
        prev_t0 = rx_t0;
        rx_idx = -1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {15'h0, tx}, 16'h1);
    chk("rst_irqn", {15'h0, irqn}, 16'h0);
    drv = 1'b1;
    dout = 8'h00;
    seln = 1'b0;
    from_devn = 1'b0;
    to_devn = 1'b1;
    #1 chk("rst_bus_z", {8'h00, bus}, 16'h0);
    idle_bus();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_irqn", {15'h0, irqn}, 16'h0);
    rd(8'h10);
    idle_bus();

    // single frame and write-to-start latency
    expect_frame(8'hA5, 1'b0);
    wr(8'hA5, 1'b0);
    chk("lat0_tx", {15'h0, tx}, 16'h1);
    chk("lat0_irqn", {15'h0, irqn}, 16'h1);
    idle_bus();
    @(posedge clk);
    #1 chk("lat1_tx", {15'h0, tx}, 16'h1);
    @(posedge clk);
    #1 chk("lat2_tx", {15'h0, tx}, 16'h0);
    wait_idle(100);
    rd(8'h10);
    idle_bus();

    // five writes back-to-back: one pop overlaps, so all five fit
    for (int i = 1; i <= 5; i++) expect_frame(8'(i), i > 1);
    for (int i = 1; i <= 5; i++) wr(8'(i), 1'b0);
    idle_bus();
    rd(8'h64);
    idle_bus();
    wait_idle(300);
    rd(8'h10);
    idle_bus();

    // overflow, clear-on-read, and push+pop while full
    expect_frame(8'h11, 1'b0);
    expect_frame(8'h22, 1'b1);
    expect_frame(8'h33, 1'b1);
    expect_frame(8'h44, 1'b1);
    expect_frame(8'h55, 1'b1);
    expect_frame(8'h88, 1'b1);
    wr(8'h11, 1'b0);
    n0 = cyc;
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    wr(8'h44, 1'b0);
    wr(8'h55, 1'b0);
    wr(8'h77, 1'b0);
    idle_bus();
    rd(8'hE4);
    idle_bus();
    rd(8'h64);
    idle_bus();
    wait_cyc(n0 + 40);
    wr(8'h88, 1'b0);
    idle_bus();
    rd(8'h64);
    idle_bus();
    wait_idle(400);
    rd(8'h10);
    idle_bus();

    // deselected strobes and write-wins decoding
    @(negedge clk);
    drv = 1'b1;
    dout = 8'h00;
    seln = 1'b1;
    to_devn = 1'b0;
    from_devn = 1'b0;
    #1 chk("sel_hi_bus", {8'h00, bus}, 16'h0);
    @(posedge clk);
    #1 chk("sel_hi_irqn", {15'h0, irqn}, 16'h0);
    idle_bus();
    rd(8'h10);
    idle_bus();
    expect_frame(8'h00, 1'b0);
    expect_frame(8'h3C, 1'b1);
    wr(8'h00, 1'b1);
    wr(8'h3C, 1'b1);
    idle_bus();
    wait_idle(200);
    rd(8'h10);
    idle_bus();

    // reset during data bit 3 of 0x52 with 0x6B queued
    wr(8'h52, 1'b0);
    n0 = cyc;
    wr(8'h6B, 1'b0);
    idle_bus();
    wait_cyc(n0 + 19);
    @(negedge clk);
    chk("pre_rst_tx", {15'h0, tx}, 16'h0);
    rst = 1'b0;
    #1 chk("rst_mid_tx", {15'h0, tx}, 16'h1);
    chk("rst_mid_irqn", {15'h0, irqn}, 16'h0);
    drv = 1'b1;
    dout = 8'h00;
    seln = 1'b0;
    from_devn = 1'b0;
    to_devn = 1'b1;
    #1 chk("rst_rd_bus", {8'h00, bus}, 16'h0);
    repeat (3) @(negedge clk);
    drv = 1'b0;
    seln = 1'b1;
    from_devn = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rd(8'h10);
    idle_bus();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_frame_after_rst", 16'(lows), 16'h0);
    chk("end_irqn", {15'h0, irqn}, 16'h0);

    chk("frames_left", 16'(exp_q.size()), 16'h0);
    chk("status_left", 16'(stat_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
